// File: rtl/fb_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fb_wr_arbiter_pkg
//   Shared definitions for the framebuffer port arbiters.
//   - arb_state_t : arbiter FSM states (idle / port granted)
//   - GRANT_W     : width of the granted-engine index (supports up to 8 engines)
//   - cnt_width() : width of a beat counter that must hold 0..max_beats
// -----------------------------------------------------------------------------
package fb_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int GRANT_W = 3;

  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches req starting one position
//   after ptr (wrapping modulo NUM_REQ) and returns the first set index.
//   Implemented as rotate -> priority-encode -> unrotate so it can be shared
//   with the read-port arbiter.
// Ports
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index of the most recently served requester
//   gnt_idx out IDX_W    selected requester (meaningful only when any=1)
//   any     out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  // One extra bit so that (index + offset) never overflows before wrapping.
  localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(NUM_REQ);

  // Both operands are < NUM_REQ, so a single conditional subtract is a full modulo.
  function automatic logic [IDX_W:0] wrap(input logic [IDX_W:0] v);
    return (v >= N_L) ? (v - N_L) : v;
  endfunction

  logic [IDX_W:0]   w_start;
  logic [IDX_W:0]   w_off;
  logic [IDX_W-1:0] w_pos;
  logic [NUM_REQ-1:0] w_rot;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_start = wrap({1'b0, ptr} + (IDX_W + 1)'(1));
    w_rot   = '0;
    w_pos   = '0;
    // Rotate: bit k of w_rot is requester (start + k) mod NUM_REQ.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos    = IDX_W'(wrap(w_start + (IDX_W + 1)'(k)));
      w_rot[k] = req[w_pos];
    end
    // Priority-encode: lowest set bit of the rotated vector wins.
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (IDX_W + 1)'(k);
    end
    // Unrotate back to an absolute requester index.
    gnt_idx = IDX_W'(wrap(w_start + w_off));
    any     = |req;
  end

endmodule

// File: rtl/fb_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fb_wr_arbiter
//   Shares the single framebuffer write port between the 2D engines.
//   Round-robin grant with burst locking: an engine keeps the port until it
//   presents a beat with req_last, or until MAX_BURST beats were accepted.
//   A single registered output stage drives the framebuffer port at up to one
//   beat per clock.
// Ports
//   clk       in   1               system clock, rising edge
//   rst_      in   1               synchronous active-low reset
//   req_rts   in   NUM_REQ         engine i has a valid write beat
//   req_rtr   out  NUM_REQ         arbiter accepts the beat from engine i
//   req_last  in   NUM_REQ         beat from engine i ends its burst
//   req_addr  in   NUM_REQ*ADDR_W  packed addresses, engine i at [i*ADDR_W +: ADDR_W]
//   req_data  in   NUM_REQ*DATA_W  packed pixels, engine i at [i*DATA_W +: DATA_W]
//   fb_rts    out  1               framebuffer beat valid
//   fb_rtr    in   1               framebuffer accepts beat
//   fb_addr   out  ADDR_W          write address
//   fb_data   out  DATA_W          write pixel
//   grant_id  out  GRANT_W         engine currently granted (valid while busy)
//   busy      out  1               an engine owns the port
// -----------------------------------------------------------------------------
module fb_wr_arbiter
  import fb_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 5,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 64
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [NUM_REQ-1:0]         req_rts,
  output logic [NUM_REQ-1:0]         req_rtr,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic                       fb_rts,
  input  logic                       fb_rtr,
  output logic [ADDR_W-1:0]          fb_addr,
  output logic [DATA_W-1:0]          fb_data,
  output logic [GRANT_W-1:0]         grant_id,
  output logic                       busy
);

  localparam int               CNT_W    = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t         r_state;
  logic [GRANT_W-1:0] r_rr_ptr;
  logic [GRANT_W-1:0] r_grant_id;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_busy;
  logic               r_fb_rts;
  logic [ADDR_W-1:0]  r_fb_addr;
  logic [DATA_W-1:0]  r_fb_data;

  logic [GRANT_W-1:0] w_pick_idx;
  logic               w_pick_any;
  logic               w_out_free;
  logic               w_sel_rts;
  logic               w_sel_last;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_accept;
  logic               w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GRANT_W)
  ) u_rr_pick (
    .req     (req_rts),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free = !r_fb_rts || fb_rtr;

  // Select the granted engine's handshake and payload.
  always_comb begin
    w_sel_rts  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GRANT_W'(i)) begin
        w_sel_rts  = req_rts[i];
        w_sel_last = req_last[i];
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the granted engine ever sees rtr, and only in GRANT.
  always_comb begin
    req_rtr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rtr[i] = (r_state == ST_GRANT) && w_out_free && (r_grant_id == GRANT_W'(i));
    end
  end

  assign w_accept  = (r_state == ST_GRANT) && w_out_free && w_sel_rts;
  // The beat being accepted either ends the burst or is the MAX_BURST-th one.
  assign w_release = w_sel_last || (r_burst_cnt == CNT_LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= GRANT_W'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
      r_fb_rts    <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= '0;
    end else begin
      // Drain the output stage; a beat loaded below in the same cycle wins.
      if (r_fb_rts && fb_rtr) r_fb_rts <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_state    <= ST_GRANT;
            r_busy     <= 1'b1;
          end
        end
        ST_GRANT: begin
          // A granted engine that pauses without last keeps the port.
          if (w_accept) begin
            r_fb_addr <= w_sel_addr;
            r_fb_data <= w_sel_data;
            r_fb_rts  <= 1'b1;
            if (w_release) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_rr_ptr    <= r_grant_id;
              r_burst_cnt <= '0;
            end else begin
              r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fb_rts   = r_fb_rts;
  assign fb_addr  = r_fb_addr;
  assign fb_data  = r_fb_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_wr_arbiter
//   Self-checking bench for fb_wr_arbiter (5 engines, MAX_BURST = 4).
//   Engine models hold each beat until accepted; expected framebuffer beats
//   are queued in the order the arbitration rules dictate and compared as
//   the framebuffer side consumes them.
// -----------------------------------------------------------------------------
module tb_fb_wr_arbiter;

  localparam int NUM_REQ   = 5;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic                       clk;
  logic                       rst_;
  logic [NUM_REQ-1:0]         req_rts;
  logic [NUM_REQ-1:0]         req_rtr;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic                       fb_rts;
  logic                       fb_rtr;
  logic [ADDR_W-1:0]          fb_addr;
  logic [DATA_W-1:0]          fb_data;
  logic [2:0]                 grant_id;
  logic                       busy;

  fb_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req_rts  (req_rts),
    .req_rtr  (req_rtr),
    .req_last (req_last),
    .req_addr (req_addr),
    .req_data (req_data),
    .fb_rts   (fb_rts),
    .fb_rtr   (fb_rtr),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench state
  beat_t eng_q [NUM_REQ][$];
  beat_t exp_q [$];
  int    took_log [$];
  bit    fb_pat [$];
  int    eng_gap   [NUM_REQ];
  int    eng_taken [NUM_REQ];
  int    gap_eng, gap_at, gap_len;
  int    stall_cnt, fb_beats;
  bit    drv_rst_n;
  bit    g_in_gap;

  // Values sampled just before each rising edge
  logic [NUM_REQ-1:0] s_rtr, s_took;
  logic               s_fb_rts, s_fb_took, s_busy;
  logic [2:0]         s_grant;
  logic [ADDR_W-1:0]  s_fb_addr;
  logic [DATA_W-1:0]  s_fb_data;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (eng_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic load_burst(input int eng, input int n, input logic [ADDR_W-1:0] abase,
                            input logic [DATA_W-1:0] dbase);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.addr = abase + ADDR_W'(k);
      b.data = dbase + DATA_W'(k);
      b.last = (k == n - 1);
      eng_q[eng].push_back(b);
    end
  endtask

  task automatic push_exp(input int first, input int n, input logic [ADDR_W-1:0] abase,
                          input logic [DATA_W-1:0] dbase);
    beat_t b;
    for (int k = first; k < first + n; k++) begin
      b.addr = abase + ADDR_W'(k);
      b.data = dbase + DATA_W'(k);
      b.last = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      eng_q[i].delete();
      eng_gap[i]   = 0;
      eng_taken[i] = 0;
    end
    exp_q.delete();
    took_log.delete();
    fb_pat.delete();
    gap_eng   = -1;
    stall_cnt = 0;
    fb_beats  = 0;
  endtask

  // One clock: drive at negedge, sample and score 1 time unit before posedge,
  // then retire accepted engine beats after the edge.
  task automatic step();
    logic [ADDR_W-1:0]  a [NUM_REQ];
    logic [DATA_W-1:0]  d [NUM_REQ];
    logic [NUM_REQ-1:0] rts, lst;
    beat_t              e;
    @(negedge clk);
    rst_     = drv_rst_n;
    g_in_gap = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a[i] = '0; d[i] = '0; rts[i] = 1'b0; lst[i] = 1'b0;
      if (eng_q[i].size() > 0) begin
        a[i] = eng_q[i][0].addr;
        d[i] = eng_q[i][0].data;
        if (eng_gap[i] > 0) begin
          eng_gap[i]--;
          g_in_gap = 1'b1;
        end else begin
          rts[i] = 1'b1;
          lst[i] = eng_q[i][0].last;
        end
      end
    end
    req_rts  = rts;
    req_last = lst;
    req_addr = {a[4], a[3], a[2], a[1], a[0]};
    req_data = {d[4], d[3], d[2], d[1], d[0]};
    fb_rtr   = (fb_pat.size() > 0) ? fb_pat.pop_front() : 1'b1;
    #4;
    s_rtr     = req_rtr;
    s_took    = req_rts & req_rtr;
    s_fb_rts  = fb_rts;
    s_fb_took = fb_rts && fb_rtr;
    s_busy    = busy;
    s_grant   = grant_id;
    s_fb_addr = fb_addr;
    s_fb_data = fb_data;

    check("rtr_onehot", ($countones(s_rtr) <= 1), 1);
    if (s_fb_rts) begin
      if (exp_q.size() == 0) begin
        check("fb_unexpected_beat", s_fb_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q[0];
        check("fb_addr", s_fb_addr, e.addr);
        check("fb_data", s_fb_data, e.data);
        if (s_fb_took) begin
          void'(exp_q.pop_front());
          fb_beats++;
        end
      end
      if (!fb_rtr) begin
        stall_cnt++;
        check("stall_rtr", s_rtr, 0);
      end
    end
    if (g_in_gap) begin
      check("gap_busy", s_busy, 1);
      check("gap_no_accept", s_took, 0);
    end

    @(posedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_took[i]) begin
        void'(eng_q[i].pop_front());
        eng_taken[i]++;
        took_log.push_back(i);
        if (i == gap_eng && eng_taken[i] == gap_at) eng_gap[i] = gap_len;
      end
    end
  endtask

  task automatic do_reset();
    drv_rst_n = 1'b0;
    step();
    clear_all();
    step();
    drv_rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pending()) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    step();
    step();
    check({tag, "_idle_after"}, s_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst_      = 1'b0;
    req_rts   = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    fb_rtr    = 1'b1;
    drv_rst_n = 1'b0;
    clear_all();

    // Reset state
    do_reset();
    step();
    check("rst_fb_rts",   s_fb_rts, 0);
    check("rst_busy",     s_busy, 0);
    check("rst_rtr",      s_rtr, 0);
    check("rst_grant_id", s_grant, 0);
    check("rst_fb_addr",  s_fb_addr, 0);
    check("rst_fb_data",  s_fb_data, 0);

    // 1: single engine, 4-beat burst, latency and throughput
    do_reset();
    load_burst(1, 4, 19'h100, 8'hA0);
    push_exp(0, 4, 19'h100, 8'hA0);
    for (int s = 0; s < 8; s++) begin
      step();
      if (s == 0) check("t1_idle_rtr", s_rtr, 0);
      if (s == 1) check("t1_fb_rts_c1", s_fb_rts, 0);
      if (s == 1) check("t1_grant_id", s_grant, 1);
      if (s >= 2 && s <= 5) check("t1_fb_consec", s_fb_took, 1);
      if (s == 4) check("t1_busy_last", s_busy, 1);
      if (s == 5) check("t1_busy_fall", s_busy, 0);
    end
    check("t1_beats", fb_beats, 4);
    check("t1_drained", exp_q.size(), 0);

    // 2: all engines single beats; round-robin fairness 0,1,2,3,4 then 0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) load_burst(i, 1, 19'h400 + 19'(i * 16), 8'h40 + 8'(i));
    load_burst(0, 1, 19'h4F0, 8'h4F);
    for (int i = 0; i < NUM_REQ; i++) push_exp(0, 1, 19'h400 + 19'(i * 16), 8'h40 + 8'(i));
    push_exp(0, 1, 19'h4F0, 8'h4F);
    drain("t2", 100);
    check("t2_count", took_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < took_log.size()) check("t2_order", took_log[k], (k == 5) ? 0 : k);
    end

    // 3: backpressure 1,0,0,1 during engine 2 burst
    do_reset();
    load_burst(2, 4, 19'h200, 8'h20);
    push_exp(0, 4, 19'h200, 8'h20);
    fb_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    drain("t3", 100);
    check("t3_stalls", stall_cnt, 3);
    check("t3_beats", fb_beats, 4);

    // 4: forced release after MAX_BURST beats
    do_reset();
    load_burst(0, 10, 19'h2000, 8'h10);
    load_burst(3, 2, 19'h3000, 8'h30);
    push_exp(0, 4, 19'h2000, 8'h10);
    push_exp(0, 2, 19'h3000, 8'h30);
    push_exp(4, 6, 19'h2000, 8'h10);
    drain("t4", 200);
    check("t4_count", took_log.size(), 12);
    if (took_log.size() >= 7) begin
      check("t4_beat4_eng", took_log[3], 0);
      check("t4_eng3_in",   took_log[4], 3);
      check("t4_eng0_back", took_log[6], 0);
    end

    // 5: reset mid-burst with a beat pending in the output register
    do_reset();
    load_burst(1, 4, 19'h500, 8'h50);
    push_exp(0, 4, 19'h500, 8'h50);
    for (int s = 0; s < 3; s++) step();
    check("t5_pre_fb_rts", s_fb_rts, 1);
    drv_rst_n = 1'b0;
    step();
    clear_all();
    drv_rst_n = 1'b1;
    step();
    check("t5_fb_rts", s_fb_rts, 0);
    check("t5_busy", s_busy, 0);
    check("t5_rtr", s_rtr, 0);
    load_burst(1, 1, 19'h510, 8'h51);
    load_burst(0, 1, 19'h520, 8'h52);
    push_exp(0, 1, 19'h520, 8'h52);
    push_exp(0, 1, 19'h510, 8'h51);
    drain("t5", 100);
    if (took_log.size() > 0) check("t5_first", took_log[0], 0);

    // 6: granted engine pauses 3 cycles without last; other engine waits
    do_reset();
    gap_eng = 1; gap_at = 2; gap_len = 3;
    load_burst(1, 4, 19'h600, 8'h60);
    load_burst(4, 1, 19'h640, 8'h64);
    push_exp(0, 4, 19'h600, 8'h60);
    push_exp(0, 1, 19'h640, 8'h64);
    drain("t6", 100);
    check("t6_count", took_log.size(), 5);
    if (took_log.size() == 5) check("t6_last_eng", took_log[4], 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
